// File: rtl/rv_run_monitor.sv
// Run monitor for a small RISC-V core: pulses core reset, supervises one run and
// reports pass/fail through a tohost mailbox, a pc-stall halt detector or a cycle budget.
//
// state    | meaning
// IDLE     | core held in reset, waiting for start
// CORE_RST | core reset pulse, RST_CYCLES clocks long
// RUN      | core released, watching mailbox, pc stall and cycle budget
// DONE     | core held in reset, result flags and count sticky until start
module rv_run_monitor #(
  parameter int              WIDTH       = 32,
  parameter int              CNT_W       = 16,
  parameter int              RST_CYCLES  = 2,
  parameter int              TIMEOUT     = 1000,
  parameter int              HALT_REPEAT = 4,
  parameter logic [WIDTH-1:0] TOHOST_ADDR = 'h100,
  parameter logic [WIDTH-1:0] PASS_VALUE  = 'd25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [WIDTH-1:0] last_pc
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int HR_W  = $clog2(HALT_REPEAT + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [HR_W-1:0]  HR_LOAD  = HR_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DONE} state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  logic [HR_W-1:0]  halt_cnt;
  logic [WIDTH-1:0] prev_pc;

  logic mb_hit, pc_same, halt_hit, to_hit, mb_pass;

  // pc compare is suppressed in the first RUN cycle, where prev_pc is stale
  always_comb begin
    mb_hit   = mem_write && (data_addr == TOHOST_ADDR);
    mb_pass  = (write_data == PASS_VALUE);
    pc_same  = (cycle_count != '0) && (pc == prev_pc);
    halt_hit = pc_same && (halt_cnt == '0);
    to_hit   = (cycle_count == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      last_pc     <= '0;
      rst_cnt     <= '0;
      halt_cnt    <= '0;
      prev_pc     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= CORE_RST;
            core_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            last_pc     <= '0;
            rst_cnt     <= RST_LOAD;
          end
        end
        CORE_RST: begin
          if (rst_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
            halt_cnt   <= HR_LOAD;
          end else begin
            rst_cnt <= rst_cnt - RST_W'(1);
          end
        end
        RUN: begin
          prev_pc  <= pc;
          halt_cnt <= pc_same ? halt_cnt - HR_W'(1) : HR_LOAD;
          if (mb_hit || halt_hit || to_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            running    <= 1'b0;
            core_reset <= 1'b1;
            last_pc    <= pc;
            if (mb_hit) begin
              pass <= mb_pass;
              fail <= !mb_pass;
            end else if (halt_hit) begin
              halted <= 1'b1;
              fail   <= 1'b1;
            end else begin
              timeout <= 1'b1;
              fail    <= 1'b1;
            end
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_run_monitor.sv
// Bench for rv_run_monitor: table of run scenarios with expected results queued
// at launch and compared at completion, plus reset and relaunch sequences.
module tb_rv_run_monitor;

  localparam int RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset, start, mem_write;
  logic [31:0] pc, data_addr, write_data;
  logic        core_reset, running, done, pass, fail, halted, timeout;
  logic [15:0] cycle_count;
  logic [31:0] last_pc;

  int checks = 0;
  int failures = 0;

  rv_run_monitor #(
    .WIDTH(32), .CNT_W(16), .RST_CYCLES(RST_CYCLES), .TIMEOUT(20),
    .HALT_REPEAT(4), .TOHOST_ADDR(32'h100), .PASS_VALUE(32'd25)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
    .core_reset(core_reset), .running(running), .done(done), .pass(pass),
    .fail(fail), .halted(halted), .timeout(timeout),
    .cycle_count(cycle_count), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mb_cyc;
    logic [31:0] mb_addr;
    logic [31:0] mb_data;
    int          hold_from;
    logic        pass;
    logic        fail;
    logic        halted;
    logic        timeout;
    int          count;
    logic [31:0] last_pc;
  } vec_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        halted;
    logic        timeout;
    int          count;
    logic [31:0] last_pc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_core_reset"}, core_reset, 1);
    chk({name, "_flags"}, {running, done, pass, fail, halted, timeout}, 0);
    chk({name, "_count"}, cycle_count, 0);
    chk({name, "_last_pc"}, last_pc, 0);
  endtask

  // waits from the start pulse until running, returns clocks spent with core_reset high
  task automatic launch(output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (core_reset && n < 10) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n, cyc;
    exp_t e, got;
    e = '{v.pass, v.fail, v.halted, v.timeout, v.count, v.last_pc};
    sb.push_back(e);
    // stores outside RUN must be ignored
    mem_write = 1'b1; data_addr = 32'h100; write_data = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_cleared", idx),
        {done, pass, fail, halted, timeout, running, core_reset}, 7'b0000001);
    chk($sformatf("v%0d_cleared_cnt", idx), {cycle_count, last_pc}, 0);
    n = 0;
    while (core_reset && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_rst_len", idx), n, RST_CYCLES);
    chk($sformatf("v%0d_running", idx), running, 1);
    cyc = 0;
    while (running && cyc < 40) begin
      chk($sformatf("v%0d_count_c%0d", idx, cyc), cycle_count, cyc);
      pc = (v.hold_from >= 0 && cyc >= v.hold_from) ? 32'h40 : 32'h1000 + 32'(4 * cyc);
      mem_write  = (cyc == v.mb_cyc);
      data_addr  = mem_write ? v.mb_addr : 32'h100;
      write_data = mem_write ? v.mb_data : 32'd25;
      @(negedge clk);
      if (running) cyc++;
    end
    mem_write = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL v%0d_done_wait actual=done=%0b required=done=1", idx, done);
    end else if (sb.size() > 0) begin
      got = sb.pop_front();
      chk($sformatf("v%0d_result", idx), {pass, fail, halted, timeout},
          {got.pass, got.fail, got.halted, got.timeout});
      chk($sformatf("v%0d_count", idx), cycle_count, got.count);
      chk($sformatf("v%0d_last_pc", idx), last_pc, got.last_pc);
      chk($sformatf("v%0d_done_state", idx), {running, core_reset}, 2'b01);
      // DONE must hold its result against further core activity
      mem_write = 1'b1; data_addr = 32'h100;
      write_data = got.pass ? 32'd7 : 32'd25;
      pc = 32'h999;
      repeat (2) @(negedge clk);
      mem_write = 1'b0;
      chk($sformatf("v%0d_sticky", idx), {done, pass, fail, halted, timeout, cycle_count, last_pc},
          {1'b1, got.pass, got.fail, got.halted, got.timeout, 16'(got.count), got.last_pc});
    end
  endtask

  initial begin
    int n;
    vt[0] = '{10, 32'h100, 32'd25, -1, 1, 0, 0, 0, 10, 32'h1028};
    vt[1] = '{10, 32'h100, 32'd7,  -1, 0, 1, 0, 0, 10, 32'h1028};
    vt[2] = '{5,  32'h104, 32'd25, -1, 0, 1, 0, 1, 19, 32'h104C};
    vt[3] = '{-1, 32'h100, 32'd25,  5, 0, 1, 1, 0,  9, 32'h40};
    vt[4] = '{-1, 32'h100, 32'd25, -1, 0, 1, 0, 1, 19, 32'h104C};
    vt[5] = '{19, 32'h100, 32'd25, -1, 1, 0, 0, 0, 19, 32'h104C};
    vt[6] = '{9,  32'h100, 32'd25,  5, 1, 0, 0, 0,  9, 32'h40};
    vt[7] = '{-1, 32'h100, 32'd25, 15, 0, 1, 1, 0, 19, 32'h40};
    vt[8] = '{-1, 32'h100, 32'd25,  0, 0, 1, 1, 0,  4, 32'h40};
    vt[9] = '{7,  32'h100, 32'd0,   3, 0, 1, 0, 0,  7, 32'h40};

    reset = 1'b1; start = 1'b1; mem_write = 1'b0;
    pc = '0; data_addr = '0; write_data = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset_over_start");
    reset = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle("idle_no_start");

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // reset while the result sits in DONE
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("reset_in_done");

    // reset mid-RUN with pc already stalled, then a clean halt run
    launch(n);
    chk("mid_run_launch", n, RST_CYCLES);
    pc = 32'h40;
    repeat (3) @(negedge clk);
    chk("mid_run_cycle", cycle_count, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("reset_mid_run");
    repeat (4) @(negedge clk);
    chk("idle_after_mid_run", running, 0);
    run_vec(vt[3], 30);

    // reset mid-CORE_RST
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("reset_mid_core_rst");
    repeat (4) @(negedge clk);
    chk("idle_after_core_rst", running, 0);

    // start ignored during RUN
    launch(n);
    pc = 32'h2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_run", {running, core_reset, cycle_count}, {1'b1, 1'b0, 16'd1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_vec(vt[0], 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
